// File: rtl/sqrt_job_scheduler_if.sv
// Bundle of the handshake signals around sqrt_job_scheduler.
//   in_*   : operand intake (valid/ready), in_data is a signed 16-bit N
//   sq_*   : start/done job link to the sqrt unit
//   out_*  : result port (valid/ready) carrying root, invalid, timeout, tag
//   fifo_count : operand entries currently queued
// Modports:
//   slave  : the scheduler itself
//   master : the environment (operand producer, sqrt unit, result consumer)
interface sqrt_job_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [15:0]            in_data;
  logic                   sq_start;
  logic [15:0]            sq_N;
  logic                   sq_done;
  logic                   sq_invalid;
  logic [7:0]             sq_ans;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_root;
  logic                   out_invalid;
  logic                   out_timeout;
  logic [TAG_W-1:0]       out_tag;
  logic [$clog2(DEPTH):0] fifo_count;

  modport slave (
    input  in_valid, in_data, sq_done, sq_invalid, sq_ans, out_ready,
    output in_ready, sq_start, sq_N, out_valid, out_root, out_invalid,
           out_timeout, out_tag, fifo_count
  );

  modport master (
    output in_valid, in_data, sq_done, sq_invalid, sq_ans, out_ready,
    input  in_ready, sq_start, sq_N, out_valid, out_root, out_invalid,
           out_timeout, out_tag, fifo_count
  );
endinterface

// File: rtl/sqrt_job_scheduler.sv
// Front end for the sqrt unit. Operands are queued in a small FIFO together
// with a wrapping job tag, issued one at a time as a start pulse, and the
// result (or a watchdog abort) is presented on a valid/ready result port.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : sqrt_job_scheduler_if.slave (operand intake, sqrt link, result port,
//           fifo_count)
module sqrt_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  sqrt_job_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [15:0]      n;
  } entry_t;

  // Operand FIFO
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Job / result state
  state_e           state_q, state_d;
  entry_t           job_q, job_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [7:0]       root_q, root_d;
  logic             inv_q, inv_d;
  logic             tmo_q, tmo_d;

  logic             push;
  logic             pop;
  logic             in_ready;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = bus.in_valid && in_ready;
  // A lingering done from the previous job must not be mistaken for the
  // completion of a fresh one, so issue waits for it to drop.
  assign pop      = (state_q == S_IDLE) && (count_q != '0) && !bus.sq_done;

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tag_d    = tag_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      tag_d    = tag_q + TAG_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Job FSM: next state and captured result fields.
  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    wdog_d  = wdog_q;
    root_d  = root_q;
    inv_d   = inv_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          job_d   = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + WD_W'(1);
        // Done is checked first so a completion on the expiry cycle still counts.
        if (bus.sq_done) begin
          root_d  = bus.sq_ans;
          inv_d   = bus.sq_invalid;
          tmo_d   = 1'b0;
          state_d = S_HOLD;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          // Last of TIMEOUT wait cycles without done: abort the job.
          root_d  = '0;
          inv_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: operand storage carries no reset; entries are only read after being written and the count gates that.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{tag: tag_q, n: bus.in_data};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
      state_q  <= S_IDLE;
      job_q    <= '0;
      wdog_q   <= '0;
      root_q   <= '0;
      inv_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tag_q    <= tag_d;
      state_q  <= state_d;
      job_q    <= job_d;
      wdog_q   <= wdog_d;
      root_q   <= root_d;
      inv_q    <= inv_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.sq_start    = (state_q == S_ISSUE);
  assign bus.sq_N        = job_q.n;        // left at the last job's value afterwards
  assign bus.out_valid   = (state_q == S_HOLD);
  assign bus.out_root    = root_q;
  assign bus.out_invalid = inv_q;
  assign bus.out_timeout = tmo_q;
  assign bus.out_tag     = job_q.tag;      // job register is frozen while holding
  assign bus.fifo_count  = count_q;

endmodule

// File: tb/tb_sqrt_job_scheduler.sv
// Directed bench for sqrt_job_scheduler: a behavioural sqrt unit answers each
// start pulse after a programmable delay (or never), a monitor logs accepted
// results, and a linear sequence of steps checks them against hand values.
module tb_sqrt_job_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int TAG_W   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sqrt_job_scheduler_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dif ();

  sqrt_job_scheduler #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT),
    .TAG_W  (TAG_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (dif)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Free-running cycle counter
  int cyc = 0;
  always @(posedge clock) cyc++;

  // Behavioural sqrt unit
  int          delay      = 10;
  bit          never_done = 1'b0;
  bit          busy       = 1'b0;
  int          cnt        = 0;
  int          starts     = 0;
  logic [15:0] model_n    = '0;

  always @(negedge clock) begin
    if (!reset) begin
      busy           = 1'b0;
      dif.sq_done    = 1'b0;
      dif.sq_invalid = 1'b0;
      dif.sq_ans     = '0;
    end else begin
      dif.sq_done = 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          int r;
          r = 0;
          if (model_n[15]) begin
            dif.sq_invalid = 1'b1;
            dif.sq_ans     = '0;
          end else begin
            while ((r + 1) * (r + 1) <= int'(model_n)) r++;
            dif.sq_invalid = 1'b0;
            dif.sq_ans     = 8'(r);
          end
          dif.sq_done = 1'b1;
          busy        = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (dif.sq_start) begin
        starts++;
        if (!never_done) begin
          busy    = 1'b1;
          cnt     = delay;
          model_n = dif.sq_N;
        end
      end
    end
  end

  // Result monitor: records every accepted result
  typedef struct {
    logic [7:0]       root;
    logic             inv;
    logic             tmo;
    logic [TAG_W-1:0] tag;
  } res_t;
  res_t res_q[$];

  always @(posedge clock) begin
    if (reset && dif.out_valid === 1'b1 && dif.out_ready === 1'b1)
      res_q.push_back('{dif.out_root, dif.out_invalid, dif.out_timeout, dif.out_tag});
  end

  task automatic push(input logic [15:0] v);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!dif.in_ready && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) check("push_ready", dif.in_ready, 1);
    dif.in_valid = 1'b1;
    dif.in_data  = v;
    @(negedge clock);
    dif.in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, output res_t r);
    int guard;
    guard = 0;
    while (res_q.size() == 0 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    check({tag, "_arrived"}, res_q.size() != 0, 1);
    if (res_q.size() != 0) r = res_q.pop_front();
    else r = '{8'hxx, 1'bx, 1'bx, 'x};
  endtask

  task automatic wait_out_valid(output bit ok);
    int guard;
    guard = 0;
    while (dif.out_valid !== 1'b1 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    ok = (dif.out_valid === 1'b1);
  endtask

  initial begin
    res_t        r;
    bit          ok;
    int          s0, t0, c, nres;
    bit          stable, saw_full;
    logic        ready_at_full;
    logic [7:0]  h_root;
    logic [3:0]  h_tag;
    logic [15:0] burst_v [6];
    logic [7:0]  burst_r [6];

    dif.in_valid  = 1'b0;
    dif.in_data   = '0;
    dif.out_ready = 1'b1;

    // Reset state
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready",   dif.in_ready, 1);
    check("rst_out_valid",  dif.out_valid, 0);
    check("rst_fifo_count", dif.fifo_count, 0);
    check("rst_sq_start",   dif.sq_start, 0);
    check("rst_sq_n",       dif.sq_N, 0);
    check("rst_out_tag",    dif.out_tag, 0);
    check("rst_out_root",   dif.out_root, 0);
    check("rst_out_timeout",dif.out_timeout, 0);
    @(negedge clock);
    reset = 1'b1;

    // 1: push 25, done 10 cycles after start
    s0 = starts;
    push(16'd25);
    check("t1_no_start_yet", dif.sq_start, 0);
    @(negedge clock);
    check("t1_start_pulse", dif.sq_start, 1);
    check("t1_sq_n", dif.sq_N, 16'd25);
    @(negedge clock);
    check("t1_start_one_cycle", dif.sq_start, 0);
    get_result("t1", r);
    check("t1_root", r.root, 5);
    check("t1_invalid", r.inv, 0);
    check("t1_timeout", r.tmo, 0);
    check("t1_tag", r.tag, 0);
    check("t1_start_count", starts - s0, 1);
    check("t1_sq_n_held", dif.sq_N, 16'd25);

    // 2: negative operand
    push(16'hFFF7);
    get_result("t2", r);
    check("t2_invalid", r.inv, 1);
    check("t2_timeout", r.tmo, 0);
    check("t2_tag", r.tag, 1);
    check("t2_sq_n_raw", dif.sq_N, 16'hFFF7);

    // 3: burst of 6 while a job is busy
    burst_v = '{16'd0, 16'd1, 16'd4, 16'd9, 16'd16, 16'd100};
    burst_r = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10};
    saw_full      = 1'b0;
    ready_at_full = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      int guard;
      guard = 0;
      dif.in_valid = 1'b1;
      dif.in_data  = burst_v[i];
      while (!dif.in_ready && guard < 300) begin
        if (dif.fifo_count == 4) begin
          saw_full      = 1'b1;
          ready_at_full = dif.in_ready;
        end
        @(negedge clock);
        guard++;
      end
      if (dif.fifo_count == 4) begin
        saw_full      = 1'b1;
        ready_at_full = dif.in_ready;
      end
      @(negedge clock);
    end
    dif.in_valid = 1'b0;
    check("t3_reached_full", saw_full, 1);
    check("t3_ready_low_when_full", ready_at_full, 0);
    for (int i = 0; i < 6; i++) begin
      get_result("t3", r);
      check($sformatf("t3_root_%0d", i), r.root, burst_r[i]);
      check($sformatf("t3_tag_%0d", i), r.tag, 4'(i + 2));
    end

    // 4: sqrt never answers -> watchdog
    never_done = 1'b1;
    push(16'd49);
    c = 0;
    while (dif.sq_start !== 1'b1 && c < 20) begin
      @(negedge clock);
      c++;
    end
    check("t4_start_seen", dif.sq_start, 1);
    t0 = cyc;
    push(16'd36);
    wait_out_valid(ok);
    check("t4_out_valid", ok, 1);
    check("t4_start_to_valid", cyc - t0, TIMEOUT + 1);
    never_done = 1'b0;
    get_result("t4", r);
    check("t4_timeout", r.tmo, 1);
    check("t4_root", r.root, 0);
    check("t4_invalid", r.inv, 0);
    check("t4_tag", r.tag, 8);
    get_result("t4_next", r);
    check("t4_next_root", r.root, 6);
    check("t4_next_timeout", r.tmo, 0);
    check("t4_next_tag", r.tag, 9);

    // 5: backpressure for 20 cycles
    @(negedge clock);
    dif.out_ready = 1'b0;
    push(16'd64);
    push(16'd81);
    wait_out_valid(ok);
    check("t5_out_valid", ok, 1);
    h_root = dif.out_root;
    h_tag  = dif.out_tag;
    check("t5_held_root", h_root, 8);
    check("t5_held_tag", h_tag, 10);
    s0     = starts;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (dif.out_valid !== 1'b1 || dif.out_root !== h_root || dif.out_tag !== h_tag ||
          dif.out_timeout !== 1'b0 || dif.sq_start !== 1'b0)
        stable = 1'b0;
    end
    check("t5_stable", stable, 1);
    check("t5_no_start", starts - s0, 0);
    check("t5_fifo_count", dif.fifo_count, 1);
    dif.out_ready = 1'b1;
    c = 0;
    while (dif.sq_start !== 1'b1 && c < 10) begin
      @(negedge clock);
      c++;
    end
    check("t5_restart_cycles", c, 2);
    get_result("t5a", r);
    check("t5a_tag", r.tag, 10);
    get_result("t5b", r);
    check("t5b_root", r.root, 9);
    check("t5b_tag", r.tag, 11);

    // 6: reset during WAIT with 3 queued
    push(16'd1);
    push(16'd2);
    push(16'd3);
    push(16'd4);
    check("t6_queued", dif.fifo_count, 3);
    check("t6_no_result_yet", dif.out_valid, 0);
    nres = res_q.size();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_count", dif.fifo_count, 0);
    check("t6_rst_out_valid", dif.out_valid, 0);
    check("t6_rst_in_ready", dif.in_ready, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    s0 = starts;
    repeat (20) @(negedge clock);
    check("t6_no_start_after", starts - s0, 0);
    check("t6_no_result_after", res_q.size() - nres, 0);
    push(16'd121);
    get_result("t6", r);
    check("t6_root", r.root, 11);
    check("t6_tag_restart", r.tag, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
